// File: rtl/sync_fifo_ctrl_pkg.sv
// Shared sizing constants and status types for the single-clock FIFO controller.
`ifndef SYNC_FIFO_CTRL_PARA
`define SYNC_FIFO_CTRL_PARA
`define A_LENGTH 3
`define AF_LEVEL_DEF 6
`define AE_LEVEL_DEF 2
`endif

package sync_fifo_ctrl_pkg;

  localparam int ADDR_W_DEF   = `A_LENGTH;
  localparam int AF_LEVEL_DEF = `AF_LEVEL_DEF;
  localparam int AE_LEVEL_DEF = `AE_LEVEL_DEF;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } status_t;

  localparam status_t STATUS_RST = '{full: 1'b0, empty: 1'b1,
                                     almost_full: 1'b0, almost_empty: 1'b1};

  function automatic int unsigned depth_of(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/sync_fifo_ctrl_bin2gray.sv
// Combinational binary-to-Gray conversion; zero latency, no flow control.
module fifo_bin2gray #(
  parameter int W = 4
) (
  input  logic [W-1:0] bin_i,
  output logic [W-1:0] gray_o
);

  assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/sync_fifo_ctrl.sv
// FIFO pointer/status sequencer for a dual-port RAM; status is registered one cycle
// after the accepted op, and writes while full / reads while empty are dropped with a pulse.
module sync_fifo_ctrl
  import sync_fifo_ctrl_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int AF_LEVEL = AF_LEVEL_DEF,
  parameter int AE_LEVEL = AE_LEVEL_DEF
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  output logic [ADDR_W:0]   wr_ptr_gray,
  output logic [ADDR_W:0]   rd_ptr_gray
);

  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] DEPTH_C = PW'(depth_of(ADDR_W));
  localparam logic [PW-1:0] AF_C    = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_C    = PW'(AE_LEVEL);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q, count_d;
  logic [PW-1:0] wr_gray_q, wr_gray_d;
  logic [PW-1:0] rd_gray_q, rd_gray_d;
  status_t       stat_q, stat_d;
  logic          rd_valid_q, overflow_q, underflow_q;
  logic          wr_acc, rd_acc;

  always_comb begin
    wr_acc   = wr_en & ~stat_q.full;
    rd_acc   = rd_en & ~stat_q.empty;
    wr_ptr_d = wr_ptr_q + PW'(wr_acc);
    rd_ptr_d = rd_ptr_q + PW'(rd_acc);
    count_d  = count_q + PW'(wr_acc) - PW'(rd_acc);

    stat_d              = STATUS_RST;
    stat_d.full         = (count_d == DEPTH_C);
    stat_d.empty        = (count_d == '0);
    stat_d.almost_full  = (count_d >= AF_C);
    stat_d.almost_empty = (count_d <= AE_C);
  end

  // Gray codes are taken from the next pointer so they land with the binary pointers.
  fifo_bin2gray #(.W(PW)) u_wr_gray (
    .bin_i  (wr_ptr_d),
    .gray_o (wr_gray_d)
  );

  fifo_bin2gray #(.W(PW)) u_rd_gray (
    .bin_i  (rd_ptr_d),
    .gray_o (rd_gray_d)
  );

  always_ff @(posedge clk_in) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_gray_q   <= '0;
      rd_gray_q   <= '0;
      stat_q      <= STATUS_RST;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_gray_q   <= wr_gray_d;
      rd_gray_q   <= rd_gray_d;
      stat_q      <= stat_d;
      rd_valid_q  <= rd_acc;
      overflow_q  <= wr_en & stat_q.full;
      underflow_q <= rd_en & stat_q.empty;
    end
  end

  assign ram_we       = wr_acc & ~reset;
  assign wr_addr      = wr_ptr_q[ADDR_W-1:0];
  assign rd_addr      = rd_ptr_q[ADDR_W-1:0];
  assign rd_valid     = rd_valid_q;
  assign full         = stat_q.full;
  assign empty        = stat_q.empty;
  assign almost_full  = stat_q.almost_full;
  assign almost_empty = stat_q.almost_empty;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign wr_ptr_gray  = wr_gray_q;
  assign rd_ptr_gray  = rd_gray_q;

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Single-clock FIFO controller that sequences a dual-port RAM-based FIFO datapath.
- Owns the write/read pointers and issues the RAM write strobe and addresses.
- Produces registered status: full, empty, almost-full, almost-empty, fill count, overflow/underflow pulses.
- Also exports Gray-coded pointers, so the existing two-stage synchronizer stages can carry them into another domain when the FIFO is later split.

Parameters:
ADDR_W, `a_length (3), RAM address width; depth DEPTH = 2**ADDR_W (8).
AF_LEVEL, 6, almost_full asserts when count >= AF_LEVEL.
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL.

Ports:
clk_in  in  1  sole clock; all logic on posedge.
reset  in  1  synchronous, active-high reset.
wr_en  in  1  write request.
rd_en  in  1  read request.
ram_we  out  1  RAM write strobe (combinational: wr_en & ~full).
wr_addr  out  ADDR_W  RAM write address (wr_ptr[ADDR_W-1:0]).
rd_addr  out  ADDR_W  RAM read address (rd_ptr[ADDR_W-1:0]).
rd_valid  out  1  RAM read data valid (cycle after accepted read).
full  out  1  FIFO holds DEPTH entries.
empty  out  1  FIFO holds 0 entries.
almost_full  out  1  count >= AF_LEVEL.
almost_empty  out  1  count <= AE_LEVEL.
count  out  ADDR_W+1  current occupancy, 0..DEPTH.
overflow  out  1  one-cycle pulse: write requested while full.
underflow  out  1  one-cycle pulse: read requested while empty.
wr_ptr_gray  out  ADDR_W+1  Gray code of wr_ptr, registered.
rd_ptr_gray  out  ADDR_W+1  Gray code of rd_ptr, registered.

Behaviour:
- Clock and reset: one clock, clk_in. Reset is synchronous and active-high, on port reset.
- Reset values: pointers 0, count 0, empty 1, almost_empty 1, full 0, almost_full 0, rd_valid 0, overflow 0, underflow 0, Gray outputs 0.
- Reset mid-operation: contents are discarded and all state returns to reset values on the next edge. ram_we is 0 while reset is high.
- Pointers: wr_ptr and rd_ptr are ADDR_W+1 bits; the MSB is the wrap bit. Each increments modulo 2**(ADDR_W+1).
- Accept rules:
  - wr_acc = wr_en & ~full
  - rd_acc = rd_en & ~empty
  - Flags used here are the registered flags.
- Pointer and count update: on the edge, wr_ptr += wr_acc and rd_ptr += rd_acc.
  - count_next = count + wr_acc - rd_acc.
  - Flags derive from count_next and are registered, so there is 1-cycle latency from an accepted op to the flag update.
- Flag definitions:
  - full = (count == DEPTH)
  - empty = (count == 0)
  - Invariant: count == wr_ptr - rd_ptr (mod 2**(ADDR_W+1)).
- Simultaneous write and read:
  - Neither flag set: both accepted; count unchanged; flags unchanged.
  - Full: read accepted, write rejected, overflow pulses; count becomes DEPTH-1.
  - Empty: write accepted, read rejected, underflow pulses; no fall-through; count becomes 1.
- rd_valid: registered rd_acc, matching a RAM with registered read output.
- overflow / underflow: registered (wr_en & full) and (rd_en & empty). Each is a single-cycle pulse per offending cycle and is not sticky.
- Gray outputs: registered bin ^ (bin >> 1) of the next pointer value, so they align with the binary pointers. At most one bit changes per cycle.
- Wrap-around: when the low ADDR_W bits go from DEPTH-1 to 0, the MSB toggles. Full vs empty is unambiguous through count.

Decomposition:
- Shared include para.h: `a_length (address width) and the AF/AE default levels as `define constants.
- One sub-module, fifo_bin2gray: parameterised width, combinational binary-to-Gray conversion. Instantiated twice, once per pointer.

Test Plan:
- Reset then idle: reset high 2 cycles, then low → empty=1, almost_empty=1, count=0, full=0, all pulses 0, Gray=0.
- Fill: 8 consecutive writes from empty → wr_addr sequence 0..7, count 1..8.
  - almost_empty deasserts after count hits 3.
  - almost_full asserts at count 6.
  - full=1 after the 8th write.
  - A 9th write gives ram_we=0 and a one-cycle overflow pulse; count stays 8.
- Drain: from full, 8 reads → rd_addr 0..7, each followed by rd_valid=1; empty=1 after the 8th read.
  - A further read gives a one-cycle underflow pulse and rd_valid=0.
- Simultaneous at boundaries:
  - Full with wr_en=rd_en=1 → count 7, overflow=1.
  - Empty with both → count 1, underflow=1, rd_valid=0.
  - count 4 with both → count stays 4, both pointers advance.
- Wrap: 20 write/read pairs at steady count 3 → addresses wrap 7→0, the pointer MSB toggles, each Gray pointer changes exactly one bit per increment, and count stays 3.
- Reset mid-operation: at count 5, assert reset for 1 cycle with wr_en=1 → ram_we=0 that cycle; next cycle count=0, empty=1, pointers and Gray outputs 0.
